// File: rtl/branch_pkg.sv
// rtl/branch_pkg.sv - MIPS conditional branch type codes and condition helpers
package branch_pkg;

   localparam logic [5:0] BR_BEQ  = 6'b001000;
   localparam logic [5:0] BR_BNE  = 6'b001001;
   localparam logic [5:0] BR_BLEZ = 6'b001010;
   localparam logic [5:0] BR_BGTZ = 6'b001011;
   localparam logic [5:0] BR_BLTZ = 6'b001100;
   localparam logic [5:0] BR_BGEZ = 6'b001101;

   // Operands are sign-extended to this width before evaluation; sign
   // extension preserves both equality and signed ordering of WIDTH-bit values.
   localparam int COND_W = 64;

   function automatic logic is_branch(input logic [5:0] br_type);
      logic w_hit;
      w_hit = 1'b0;
      case (br_type)
         BR_BEQ, BR_BNE, BR_BLEZ, BR_BGTZ, BR_BLTZ, BR_BGEZ: w_hit = 1'b1;
         default:                                            w_hit = 1'b0;
      endcase
      return w_hit;
   endfunction

   function automatic logic cond_eval(input logic [5:0]               br_type,
                                      input logic signed [COND_W-1:0] in1,
                                      input logic signed [COND_W-1:0] in2);
      logic w_cond;
      w_cond = 1'b0;
      case (br_type)
         BR_BEQ:  w_cond = (in1 == in2);
         BR_BNE:  w_cond = (in1 != in2);
         BR_BLEZ: w_cond = (in1 <= 0);
         BR_BGTZ: w_cond = (in1 >  0);
         BR_BLTZ: w_cond = (in1 <  0);
         BR_BGEZ: w_cond = (in1 >= 0);
         default: w_cond = 1'b0;
      endcase
      return w_cond;
   endfunction

endpackage

// File: rtl/bht_sat_ctr_array.sv
// rtl/bht_sat_ctr_array.sv - table of saturating counters, one async read and one sync write port
module bht_sat_ctr_array #(
   parameter int IDX_BITS = 4,
   parameter int CTR_BITS = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [IDX_BITS-1:0] i_rd_idx,
   output logic [CTR_BITS-1:0] o_rd_ctr,
   input  logic                i_wr_en,
   input  logic                i_wr_inc,
   input  logic [IDX_BITS-1:0] i_wr_idx
);

   localparam int DEPTH = 2 ** IDX_BITS;
   localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'((2 ** (CTR_BITS - 1)) - 1);
   localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;

   logic [CTR_BITS-1:0] r_ctr [DEPTH];

   // Read returns the pre-update value when it hits the entry being written.
   assign o_rd_ctr = r_ctr[i_rd_idx];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_ctr[i] <= CTR_INIT;
         end
      end else if (i_wr_en) begin
         if (i_wr_inc) begin
            if (r_ctr[i_wr_idx] != CTR_MAX) begin
               r_ctr[i_wr_idx] <= r_ctr[i_wr_idx] + CTR_BITS'(1);
            end
         end else if (r_ctr[i_wr_idx] != '0) begin
            r_ctr[i_wr_idx] <= r_ctr[i_wr_idx] - CTR_BITS'(1);
         end
      end
   end

endmodule

// File: rtl/branch_resolve_bht.sv
// rtl/branch_resolve_bht.sv - branch resolution with registered result, BHT training and mispredict count
module branch_resolve_bht
   import branch_pkg::*;
#(
   parameter int WIDTH    = 32,
   parameter int IDX_BITS = 4,
   parameter int CTR_BITS = 2,
   parameter int CNT_BITS = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [31:0]         f_pc,
   output logic                f_pred_taken,
   input  logic                r_valid,
   input  logic [31:0]         r_pc,
   input  logic [5:0]          r_type,
   input  logic [WIDTH-1:0]    r_in1,
   input  logic [WIDTH-1:0]    r_in2,
   input  logic                r_pred,
   input  logic                flush,
   output logic                res_valid,
   output logic                res_taken,
   output logic                res_mispredict,
   output logic [CNT_BITS-1:0] mispredict_cnt
);

   logic signed [COND_W-1:0] w_in1;
   logic signed [COND_W-1:0] w_in2;
   logic                     w_accept;
   logic                     w_cond;
   logic                     w_mis;
   logic [CTR_BITS-1:0]      w_rd_ctr;
   logic                     w_unused_pc_bits;

   logic                     r_out_valid;
   logic                     r_out_taken;
   logic                     r_out_mis;
   logic [CNT_BITS-1:0]      r_mis_cnt;

   assign w_in1    = COND_W'($signed(r_in1));
   assign w_in2    = COND_W'($signed(r_in2));
   assign w_accept = r_valid & ~flush & is_branch(r_type);
   assign w_cond   = cond_eval(r_type, w_in1, w_in2);
   assign w_mis    = w_cond ^ r_pred;

   // Only word-aligned index bits select an entry; the rest alias freely.
   assign w_unused_pc_bits = ^{f_pc[31:IDX_BITS+2], f_pc[1:0],
                               r_pc[31:IDX_BITS+2], r_pc[1:0]};

   bht_sat_ctr_array #(
      .IDX_BITS (IDX_BITS),
      .CTR_BITS (CTR_BITS)
   ) u_bht (
      .clk      (clk),
      .rst_n    (reset),
      .i_rd_idx (f_pc[IDX_BITS+1:2]),
      .o_rd_ctr (w_rd_ctr),
      .i_wr_en  (w_accept),
      .i_wr_inc (w_cond),
      .i_wr_idx (r_pc[IDX_BITS+1:2])
   );

   assign f_pred_taken = w_rd_ctr[CTR_BITS-1];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_out_valid <= 1'b0;
         r_out_taken <= 1'b0;
         r_out_mis   <= 1'b0;
         r_mis_cnt   <= '0;
      end else begin
         r_out_valid <= w_accept;
         r_out_taken <= w_accept & w_cond;
         r_out_mis   <= w_accept & w_mis;
         if (w_accept && w_mis && (r_mis_cnt != '1)) begin
            r_mis_cnt <= r_mis_cnt + CNT_BITS'(1);
         end
      end
   end

   assign res_valid      = r_out_valid;
   assign res_taken      = r_out_taken;
   assign res_mispredict = r_out_mis;
   assign mispredict_cnt = r_mis_cnt;

endmodule

// File: tb/tb_branch_resolve_bht.sv
// tb/tb_branch_resolve_bht.sv - directed self-checking bench for branch_resolve_bht
module tb_branch_resolve_bht;

   localparam logic [5:0] T_BEQ  = 6'b001000;
   localparam logic [5:0] T_BNE  = 6'b001001;
   localparam logic [5:0] T_BLEZ = 6'b001010;
   localparam logic [5:0] T_BGTZ = 6'b001011;
   localparam logic [5:0] T_BLTZ = 6'b001100;
   localparam logic [5:0] T_BGEZ = 6'b001101;

   logic        clk;
   logic        reset;
   logic [31:0] f_pc;
   logic        f_pred_taken;
   logic        r_valid;
   logic [31:0] r_pc;
   logic [5:0]  r_type;
   logic [31:0] r_in1;
   logic [31:0] r_in2;
   logic        r_pred;
   logic        flush;
   logic        res_valid;
   logic        res_taken;
   logic        res_mispredict;
   logic [15:0] mispredict_cnt;

   logic        s_pred_taken;
   logic        s_res_valid;
   logic        s_res_taken;
   logic        s_res_mispredict;
   logic [1:0]  s_cnt;

   int n_checks = 0;
   int n_errors = 0;

   branch_resolve_bht dut (
      .clk            (clk),
      .reset          (reset),
      .f_pc           (f_pc),
      .f_pred_taken   (f_pred_taken),
      .r_valid        (r_valid),
      .r_pc           (r_pc),
      .r_type         (r_type),
      .r_in1          (r_in1),
      .r_in2          (r_in2),
      .r_pred         (r_pred),
      .flush          (flush),
      .res_valid      (res_valid),
      .res_taken      (res_taken),
      .res_mispredict (res_mispredict),
      .mispredict_cnt (mispredict_cnt)
   );

   branch_resolve_bht #(.CNT_BITS(2)) dut_small (
      .clk            (clk),
      .reset          (reset),
      .f_pc           (f_pc),
      .f_pred_taken   (s_pred_taken),
      .r_valid        (r_valid),
      .r_pc           (r_pc),
      .r_type         (r_type),
      .r_in1          (r_in1),
      .r_in2          (r_in2),
      .r_pred         (r_pred),
      .flush          (flush),
      .res_valid      (s_res_valid),
      .res_taken      (s_res_taken),
      .res_mispredict (s_res_mispredict),
      .mispredict_cnt (s_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Present one branch, cross the edge, sample results 1 time unit later.
   task automatic resolve(input logic [5:0] t, input logic [31:0] pc, input logic [31:0] a,
                          input logic [31:0] b, input logic pred, input logic fl);
      r_type  = t;
      r_pc    = pc;
      r_in1   = a;
      r_in2   = b;
      r_pred  = pred;
      flush   = fl;
      r_valid = 1'b1;
      @(posedge clk);
      #1;
      r_valid = 1'b0;
      flush   = 1'b0;
   endtask

   task automatic expect_res(input string tag, input logic v, input logic t, input logic m,
                             input logic [15:0] cnt);
      check({tag, "_valid"}, 32'(res_valid), 32'(v));
      check({tag, "_taken"}, 32'(res_taken), 32'(t));
      check({tag, "_mis"},   32'(res_mispredict), 32'(m));
      check({tag, "_cnt"},   32'(mispredict_cnt), 32'(cnt));
   endtask

   initial begin
      reset = 1'b0; f_pc = 32'h0; r_valid = 1'b0; r_pc = 32'h0; r_type = 6'h0;
      r_in1 = 32'h0; r_in2 = 32'h0; r_pred = 1'b0; flush = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      f_pc = 32'h3000;
      #1;
      check("rst_pred", 32'(f_pred_taken), 32'd0);
      @(posedge clk); #1;
      expect_res("rst", 1'b0, 1'b0, 1'b0, 16'd0);

      resolve(T_BEQ, 32'h3000, 32'd5, 32'd5, 1'b0, 1'b0);
      expect_res("beq1", 1'b1, 1'b1, 1'b1, 16'd1);
      check("beq1_pred", 32'(f_pred_taken), 32'd1);
      resolve(T_BEQ, 32'h3000, 32'd5, 32'd5, 1'b0, 1'b0);
      expect_res("beq2", 1'b1, 1'b1, 1'b1, 16'd2);
      check("beq2_small_cnt", 32'(s_cnt), 32'd2);

      resolve(T_BLTZ, 32'h3010, 32'hFFFF_FFFF, 32'd0, 1'b1, 1'b0);
      expect_res("bltz_m1", 1'b1, 1'b1, 1'b0, 16'd2);
      resolve(T_BGEZ, 32'h3010, 32'hFFFF_FFFF, 32'd0, 1'b1, 1'b0);
      expect_res("bgez_m1", 1'b1, 1'b0, 1'b1, 16'd3);
      resolve(T_BLEZ, 32'h3010, 32'hFFFF_FFFF, 32'd0, 1'b1, 1'b0);
      expect_res("blez_m1", 1'b1, 1'b1, 1'b0, 16'd3);
      resolve(T_BGTZ, 32'h3010, 32'hFFFF_FFFF, 32'd0, 1'b1, 1'b0);
      expect_res("bgtz_m1", 1'b1, 1'b0, 1'b1, 16'd4);
      check("small_cnt_sat", 32'(s_cnt), 32'd3);
      resolve(T_BLEZ, 32'h3010, 32'd0, 32'd7, 1'b1, 1'b0);
      expect_res("blez_0", 1'b1, 1'b1, 1'b0, 16'd4);
      resolve(T_BGEZ, 32'h3010, 32'd0, 32'd7, 1'b1, 1'b0);
      expect_res("bgez_0", 1'b1, 1'b1, 1'b0, 16'd4);
      resolve(T_BGTZ, 32'h3010, 32'h7FFF_FFFF, 32'd0, 1'b1, 1'b0);
      expect_res("bgtz_max", 1'b1, 1'b1, 1'b0, 16'd4);
      resolve(T_BLTZ, 32'h3010, 32'h8000_0000, 32'd0, 1'b1, 1'b0);
      expect_res("bltz_min", 1'b1, 1'b1, 1'b0, 16'd4);

      f_pc = 32'h3020;
      for (int i = 0; i < 5; i++) begin
         resolve(T_BNE, 32'h3020, 32'd1, 32'd2, 1'b1, 1'b0);
      end
      expect_res("bne_sat", 1'b1, 1'b1, 1'b0, 16'd4);
      check("bne_sat_pred", 32'(f_pred_taken), 32'd1);
      resolve(T_BNE, 32'h3020, 32'd7, 32'd7, 1'b1, 1'b0);
      expect_res("bne_nt1", 1'b1, 1'b0, 1'b1, 16'd5);
      check("bne_nt1_pred", 32'(f_pred_taken), 32'd1);
      resolve(T_BNE, 32'h3020, 32'd7, 32'd7, 1'b1, 1'b0);
      expect_res("bne_nt2", 1'b1, 1'b0, 1'b1, 16'd6);
      check("bne_nt2_pred", 32'(f_pred_taken), 32'd0);
      check("small_cnt_hold", 32'(s_cnt), 32'd3);

      f_pc = 32'h3030;
      resolve(T_BEQ, 32'h3030, 32'd9, 32'd9, 1'b0, 1'b1);
      expect_res("flush", 1'b0, 1'b0, 1'b0, 16'd6);
      check("flush_pred", 32'(f_pred_taken), 32'd0);
      resolve(6'b000000, 32'h3030, 32'd9, 32'd9, 1'b0, 1'b0);
      expect_res("nonbr0", 1'b0, 1'b0, 1'b0, 16'd6);
      resolve(6'b001110, 32'h3030, 32'd9, 32'd9, 1'b0, 1'b0);
      expect_res("nonbr_e", 1'b0, 1'b0, 1'b0, 16'd6);
      check("nonbr_pred", 32'(f_pred_taken), 32'd0);

      r_type = T_BEQ; r_pc = 32'h3030; r_in1 = 32'd3; r_in2 = 32'd3; r_pred = 1'b0;
      r_valid = 1'b1;
      #1;
      check("same_pre", 32'(f_pred_taken), 32'd0);
      @(posedge clk); #1;
      r_valid = 1'b0;
      expect_res("same", 1'b1, 1'b1, 1'b1, 16'd7);
      check("same_post", 32'(f_pred_taken), 32'd1);
      f_pc = 32'h0001_3030;
      #1;
      check("alias_pred", 32'(f_pred_taken), 32'd1);

      resolve(T_BEQ, 32'h3000, 32'd1, 32'd1, 1'b0, 1'b0);
      expect_res("pre_rst", 1'b1, 1'b1, 1'b1, 16'd8);
      f_pc = 32'h3000;
      #2 reset = 1'b0;
      #1;
      expect_res("async_rst", 1'b0, 1'b0, 1'b0, 16'd0);
      check("async_rst_pred", 32'(f_pred_taken), 32'd0);
      check("async_rst_small", 32'(s_cnt), 32'd0);
      @(posedge clk); #1 reset = 1'b1;
      @(posedge clk); #1;
      expect_res("post_rst", 1'b0, 1'b0, 1'b0, 16'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
